// File: rtl/mem_access_ctrl_if.sv
// Bundles the three sides of the memory access controller into one interface:
//   - the pipeline request channel (req_*)
//   - the pipeline response channel (resp_*)
//   - the RAM port (ram_*)
// The slave modport is the controller's view. The master modport is the
// environment's view: the pipeline stage plus the RAM.
interface mem_access_ctrl_if;

    // Pipeline request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // Pipeline response channel
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // RAM port (ram_rdata is registered inside the RAM)
    logic        ram_read;
    logic        ram_write;
    logic        ram_word;
    logic        ram_sign;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_word,
        input  req_sign,
        input  req_addr,
        input  req_wdata,
        input  resp_ready,
        input  ram_rdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output ram_read,
        output ram_write,
        output ram_word,
        output ram_sign,
        output ram_addr,
        output ram_wdata
    );

    modport master (
        output req_valid,
        output req_write,
        output req_word,
        output req_sign,
        output req_addr,
        output req_wdata,
        output resp_ready,
        output ram_rdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  ram_read,
        input  ram_write,
        input  ram_word,
        input  ram_sign,
        input  ram_addr,
        input  ram_wdata
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller between a pipeline MEM stage and a word-wide RAM.
//
// Behaviour:
//   - Accepts one load or store at a time.
//   - Every RAM read is a full word. Half-word load formatting is done here.
//   - Half-word stores use a read-modify-write sequence: read the word, merge
//     the new low half, then write the word back.
//   - The response is held until the pipeline consumes it.
//
// Optional feature: MISALIGN_CHECK_EN.
//   - When defined, misaligned accesses bypass the RAM and respond
//     immediately with resp_err set.
//   - When undefined, resp_err is tied low and misaligned addresses are
//     passed to the RAM unchanged.
module mem_access_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD      = 3'd1,
        LD_CAP  = 3'd2,
        RMW_RD  = 3'd3,
        RMW_CAP = 3'd4,
        ST      = 3'd5,
        RESP    = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Request fields captured at the accept edge
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        word_q;
    logic        sign_q;

    // Word to write back for a half store, and the registered response data
    logic [31:0] merge_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        misalign;

    // Decoded from the registered state only (before the reset gate)
    logic        req_ready_c;
    logic        resp_valid_c;
    logic        ram_read_c;
    logic        ram_write_c;

    // Format a full RAM word as load data: the whole word, or the low half
    // sign- or zero-extended.
    function automatic logic [31:0] fmt_load(input logic [31:0] raw,
                                             input logic        word,
                                             input logic        sign);
        logic signed [15:0] half_s;
        logic signed [31:0] half_ext;
        half_s   = raw[15:0];
        half_ext = half_s;
        if (word)
            return raw;
        else if (sign)
            return half_ext;
        else
            return {16'd0, raw[15:0]};
    endfunction

    // Replace the low half of the stored word with the new store half.
    function automatic logic [31:0] merge_half(input logic [31:0] raw,
                                               input logic [15:0] half);
        return {raw[31:16], half};
    endfunction

    assign accept = bus.req_valid && (state == IDLE);

`ifdef MISALIGN_CHECK_EN
    logic err_q;

    // A word access needs addr[1:0] == 0; a half access needs addr[0] == 0
    assign misalign = bus.req_word ? (bus.req_addr[1:0] != 2'b00)
                                   : bus.req_addr[0];

    // The error flag is decided once, at acceptance, and held through RESP
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (accept)
            err_q <= misalign;
    end

    assign bus.resp_err = err_q;
`else
    assign misalign     = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and per-state output decode
    always_comb begin
        state_nxt    = state;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        ram_read_c   = 1'b0;
        ram_write_c  = 1'b0;

        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    if (misalign)
                        state_nxt = RESP;
                    else if (!bus.req_write)
                        state_nxt = LD;
                    else if (bus.req_word)
                        state_nxt = ST;
                    else
                        state_nxt = RMW_RD;
                end
            end

            LD: begin
                ram_read_c = 1'b1;
                state_nxt  = LD_CAP;
            end

            LD_CAP: begin
                state_nxt = RESP;
            end

            RMW_RD: begin
                ram_read_c = 1'b1;
                state_nxt  = RMW_CAP;
            end

            RMW_CAP: begin
                state_nxt = ST;
            end

            ST: begin
                ram_write_c = 1'b1;
                state_nxt   = RESP;
            end

            RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready)
                    state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the request at acceptance and capture RAM data in the capture
    // states. resp_rdata is cleared at acceptance, so stores and misaligned
    // accesses respond with zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
            word_q  <= 1'b0;
            sign_q  <= 1'b0;
            merge_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
                word_q  <= bus.req_word;
                sign_q  <= bus.req_sign;
                merge_q <= 32'd0;
                rdata_q <= 32'd0;
            end

            if (state == LD_CAP && !write_q)
                rdata_q <= fmt_load(bus.ram_rdata, word_q, sign_q);

            if (state == RMW_CAP)
                merge_q <= merge_half(bus.ram_rdata, wdata_q[15:0]);
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_rdata = rdata_q;

    // RAM strobes are gated by reset directly, so a reset arriving mid-access
    // never reaches the RAM.
    assign bus.ram_read  = ram_read_c  && rst_n;
    assign bus.ram_write = ram_write_c && rst_n;
    assign bus.ram_word  = 1'b1;
    assign bus.ram_sign  = 1'b0;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = word_q ? wdata_q : merge_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl.
//
// The bench contains a small word-wide RAM model with registered read data.
// Latency is counted in cycles after the accept edge: cycle 1 is the cycle
// that directly follows the accept edge.
module tb_mem_access_ctrl;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [31:0] mem [0:255];

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write; read data is registered one cycle
    always @(posedge clk) begin
        if (bus.ram_read)
            bus.ram_rdata <= mem[bus.ram_addr[9:2]];
        if (bus.ram_write)
            mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
    end

    // Run one transaction with resp_ready held high.
    // Collects latency, response fields and RAM activity; a latency of -1
    // means the response never arrived within the cycle budget.
    task automatic do_req(input  logic        wr,
                          input  logic        word,
                          input  logic        sign,
                          input  logic [31:0] addr,
                          input  logic [31:0] wdata,
                          output int          lat,
                          output logic [31:0] rdata,
                          output logic        err,
                          output int          nrd,
                          output int          nwr,
                          output logic [31:0] wval);
        lat   = -1;
        rdata = 32'd0;
        err   = 1'b0;
        nrd   = 0;
        nwr   = 0;
        wval  = 32'd0;

        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_word  = word;
        bus.req_sign  = sign;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        for (int c = 1; c <= 20; c++) begin
            if (bus.ram_read)
                nrd++;
            if (bus.ram_write) begin
                nwr++;
                wval = bus.ram_wdata;
            end
            if (bus.resp_valid) begin
                lat   = c;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end

        // The response is consumed at this edge
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_word   = 1'b0;
        bus.req_sign   = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b1;
        rst_n          = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ram_read !== 1'b0 || bus.ram_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_ram_strobes: got rd=%b wr=%b expected 0/0",
                     bus.ram_read, bus.ram_write);
        end

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_req_ready: got %b expected 1", bus.req_ready);
        end
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp_valid: got %b expected 0", bus.resp_valid);
        end
        checks++;
        if (bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp_data: got %h err=%b expected 00000000 err=0",
                     bus.resp_rdata, bus.resp_err);
        end
        checks++;
        if (bus.ram_word !== 1'b1 || bus.ram_sign !== 1'b0) begin
            errors++;
            $display("FAIL rst_ram_ties: got word=%b sign=%b expected 1/0",
                     bus.ram_word, bus.ram_sign);
        end
    endtask

    task automatic test_word_store_load;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] rd;
        logic [31:0] wv;
        logic        er;

        do_req(1'b1, 1'b1, 1'b0, 32'd400, 32'hF00FF176, lat, rd, er, nrd, nwr, wv);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL wst_latency: got %0d expected 2", lat);
        end
        checks++;
        if (nwr !== 1 || nrd !== 0) begin
            errors++;
            $display("FAIL wst_ram_ops: got wr=%0d rd=%0d expected 1/0", nwr, nrd);
        end
        checks++;
        if (wv !== 32'hF00FF176) begin
            errors++;
            $display("FAIL wst_wdata: got %h expected f00ff176", wv);
        end
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL wst_rdata: got %h expected 00000000", rd);
        end

        do_req(1'b0, 1'b1, 1'b0, 32'd400, 32'd0, lat, rd, er, nrd, nwr, wv);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL wld_latency: got %0d expected 3", lat);
        end
        checks++;
        if (rd !== 32'hF00FF176) begin
            errors++;
            $display("FAIL wld_rdata: got %h expected f00ff176", rd);
        end
        checks++;
        if (nrd !== 1 || nwr !== 0 || er !== 1'b0) begin
            errors++;
            $display("FAIL wld_ram_ops: got rd=%0d wr=%0d err=%b expected 1/0/0",
                     nrd, nwr, er);
        end
    endtask

    task automatic test_half_store;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] rd;
        logic [31:0] wv;
        logic        er;

        do_req(1'b1, 1'b0, 1'b0, 32'd400, 32'h0000ABCD, lat, rd, er, nrd, nwr, wv);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL hst_latency: got %0d expected 4", lat);
        end
        checks++;
        if (nrd !== 1 || nwr !== 1) begin
            errors++;
            $display("FAIL hst_ram_ops: got rd=%0d wr=%0d expected 1/1", nrd, nwr);
        end
        checks++;
        if (wv !== 32'hF00FABCD) begin
            errors++;
            $display("FAIL hst_wdata: got %h expected f00fabcd", wv);
        end
        checks++;
        if (mem[100] !== 32'hF00FABCD) begin
            errors++;
            $display("FAIL hst_mem: got %h expected f00fabcd", mem[100]);
        end

        // Restore the original word for the following tests
        do_req(1'b1, 1'b1, 1'b0, 32'd400, 32'hF00FF176, lat, rd, er, nrd, nwr, wv);
        checks++;
        if (mem[100] !== 32'hF00FF176) begin
            errors++;
            $display("FAIL hst_restore: got %h expected f00ff176", mem[100]);
        end
    endtask

    task automatic test_half_load;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] rd;
        logic [31:0] wv;
        logic        er;

        do_req(1'b0, 1'b0, 1'b1, 32'd400, 32'd0, lat, rd, er, nrd, nwr, wv);
        checks++;
        if (rd !== 32'hFFFFF176 || lat !== 3) begin
            errors++;
            $display("FAIL hld_signed: got %h lat=%0d expected fffff176 lat=3", rd, lat);
        end

        do_req(1'b0, 1'b0, 1'b0, 32'd400, 32'd0, lat, rd, er, nrd, nwr, wv);
        checks++;
        if (rd !== 32'h0000F176 || lat !== 3) begin
            errors++;
            $display("FAIL hld_unsigned: got %h lat=%0d expected 0000f176 lat=3", rd, lat);
        end

        do_req(1'b0, 1'b1, 1'b1, 32'd400, 32'd0, lat, rd, er, nrd, nwr, wv);
        checks++;
        if (rd !== 32'hF00FF176) begin
            errors++;
            $display("FAIL wld_sign_ignored: got %h expected f00ff176", rd);
        end
    endtask

    task automatic test_backpressure;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_word   = 1'b1;
        bus.req_sign   = 1'b0;
        bus.req_addr   = 32'd400;
        bus.req_wdata  = 32'd0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        for (int c = 0; c < 20 && !bus.resp_valid; c++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (bus.resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_resp_arrive: got %b expected 1", bus.resp_valid);
        end

        // Offer a store while the response is stalled; it must be ignored
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_wdata = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hF00FF176 ||
                bus.req_ready !== 1'b0 || bus.ram_write !== 1'b0 ||
                bus.ram_read !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got vld=%b data=%h rdy=%b wr=%b rd=%b expected 1/f00ff176/0/0/0",
                         c, bus.resp_valid, bus.resp_rdata, bus.req_ready,
                         bus.ram_write, bus.ram_read);
            end
        end

        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b expected 0/1",
                     bus.resp_valid, bus.req_ready);
        end
        checks++;
        if (mem[100] !== 32'hF00FF176) begin
            errors++;
            $display("FAIL bp_mem: got %h expected f00ff176", mem[100]);
        end
    endtask

    task automatic test_reset_in_store;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_word  = 1'b1;
        bus.req_sign  = 1'b0;
        bus.req_addr  = 32'd400;
        bus.req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        // The controller is now in ST; assert reset before the write edge
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ram_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_st_write: got %b expected 0", bus.ram_write);
        end

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem[100] !== 32'hF00FF176) begin
            errors++;
            $display("FAIL rst_st_mem: got %h expected f00ff176", mem[100]);
        end
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_st_state: got vld=%b rdy=%b expected 0/1",
                     bus.resp_valid, bus.req_ready);
        end

        @(posedge clk);
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.ram_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_st_after: got vld=%b wr=%b expected 0/0",
                     bus.resp_valid, bus.ram_write);
        end
    endtask

    task automatic test_misalign;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] rd;
        logic [31:0] wv;
        logic        er;

        do_req(1'b0, 1'b1, 1'b0, 32'd401, 32'd0, lat, rd, er, nrd, nwr, wv);
`ifdef MISALIGN_CHECK_EN
        checks++;
        if (lat !== 1 || nrd !== 0) begin
            errors++;
            $display("FAIL mis_bypass: got lat=%0d rd=%0d expected 1/0", lat, nrd);
        end
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL mis_resp: got err=%b data=%h expected 1/00000000", er, rd);
        end
`else
        checks++;
        if (lat !== 3 || nrd !== 1) begin
            errors++;
            $display("FAIL mis_normal: got lat=%0d rd=%0d expected 3/1", lat, nrd);
        end
        checks++;
        if (er !== 1'b0 || rd !== 32'hF00FF176) begin
            errors++;
            $display("FAIL mis_resp: got err=%b data=%h expected 0/f00ff176", er, rd);
        end
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_word_store_load();
        test_half_store();
        test_half_load();
        test_backpressure();
        test_reset_in_store();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
